// File: rtl/mem_bank_cfg_pkg.sv
// Shared types and sizing helpers for the memory-bank configuration programmer.
//   state_e        : programmer FSM states
//   words_per_row  : stream words needed to fill one bitline row
//   cnt_w          : counter width able to hold 0..n-1 (never narrower than 1)
package mem_bank_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD
    } state_e;

    function automatic int words_per_row(input int bl_width, input int data_w);
        return (bl_width + data_w - 1) / data_w;
    endfunction

    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_BL_WIDTH = 315;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_WPR      = words_per_row(DEF_BL_WIDTH, DEF_DATA_W);
    localparam int DEF_WCNT_W   = cnt_w(DEF_WPR);

endpackage

// File: rtl/mem_bank_cfg_programmer_row_buffer.sv
// Row assembly buffer: collects WPR stream words into one BL_WIDTH row.
//   clk, reset  : clock, async active-low reset
//   clr         : synchronous clear of row and word counter (wins over wr_en)
//   wr_en       : write wr_data into the word slot selected by the counter
//   wr_data     : stream word; bits beyond BL_WIDTH in the last word are dropped
//   full        : high on the cycle the last word of the row is written
//   row         : row contents including the word being written this cycle,
//                 so the consumer can latch a complete row on the same edge
module cfg_row_buffer
    import mem_bank_cfg_pkg::*;
#(
    parameter int BL_WIDTH = 315,
    parameter int DATA_W   = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                wr_en,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                full,
    output logic [BL_WIDTH-1:0] row
);

    localparam int WPR = words_per_row(BL_WIDTH, DATA_W);
    localparam int CW  = cnt_w(WPR);

    logic [CW-1:0]       wcnt_q;
    logic [BL_WIDTH-1:0] row_q;
    logic [BL_WIDTH-1:0] row_d;

    // One slice per word; the last slice is narrowed to the bits that exist.
    for (genvar k = 0; k < WPR; k++) begin : g_word
        localparam int LO = k * DATA_W;
        localparam int W  = (BL_WIDTH - LO < DATA_W) ? (BL_WIDTH - LO) : DATA_W;
        assign row_d[LO +: W] = (wr_en && wcnt_q == CW'(k)) ? wr_data[W-1:0]
                                                            : row_q[LO +: W];
    end

    assign full = wr_en && (wcnt_q == CW'(WPR - 1));
    assign row  = row_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wcnt_q <= '0;
            row_q  <= '0;
        end else if (clr) begin
            wcnt_q <= '0;
            row_q  <= '0;
        end else if (wr_en) begin
            row_q  <= row_d;
            wcnt_q <= full ? '0 : wcnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/mem_bank_cfg_programmer.sv
// Memory-bank configuration initiator. Streams WL_WIDTH rows of BL_WIDTH bits,
// drives each row onto the bitline chain and strobes the matching wordline
// with SETUP/PULSE/HOLD timing.
//   clk, reset          : clock, async active-low reset
//   start, abort        : session start (IDLE only), synchronous abort
//   cfg_data/valid/ready: bitstream word handshake
//   bl, wl              : bitline and one-hot wordline drive to the tile chain
//   busy, done, row_idx : session status, last-row completion pulse, row index
// All outputs come straight from flops.
module mem_bank_cfg_programmer
    import mem_bank_cfg_pkg::*;
#(
    parameter int BL_WIDTH  = 315,
    parameter int WL_WIDTH  = 4,
    parameter int DATA_W    = 32,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        abort,
    input  logic [DATA_W-1:0]           cfg_data,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    output logic [BL_WIDTH-1:0]         bl,
    output logic [WL_WIDTH-1:0]         wl,
    output logic                        busy,
    output logic                        done,
    output logic [$clog2(WL_WIDTH)-1:0] row_idx
);

    localparam int RW      = $clog2(WL_WIDTH);
    localparam int CYC_MAX = (SETUP_CYC > PULSE_CYC)
                           ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                           : ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
    localparam int CYW     = cnt_w(CYC_MAX);

    state_e              state_q;
    logic [CYW-1:0]      cyc_q;
    logic [RW-1:0]       row_idx_q;
    logic [BL_WIDTH-1:0] bl_q;
    logic [WL_WIDTH-1:0] wl_q;
    logic                cfg_ready_q;
    logic                busy_q;
    logic                done_q;

    logic                buf_clr;
    logic                buf_wr;
    logic                buf_full;
    logic [BL_WIDTH-1:0] buf_row;

    // Buffer is held empty while idle so every session starts at word 0.
    assign buf_clr = (state_q == ST_IDLE) || abort;
    assign buf_wr  = cfg_valid && cfg_ready_q;

    cfg_row_buffer #(
        .BL_WIDTH (BL_WIDTH),
        .DATA_W   (DATA_W)
    ) u_row_buf (
        .clk     (clk),
        .reset   (reset),
        .clr     (buf_clr),
        .wr_en   (buf_wr),
        .wr_data (cfg_data),
        .full    (buf_full),
        .row     (buf_row)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cyc_q       <= '0;
            row_idx_q   <= '0;
            bl_q        <= '0;
            wl_q        <= '0;
            cfg_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort && state_q != ST_IDLE) begin
                state_q     <= ST_IDLE;
                cyc_q       <= '0;
                row_idx_q   <= '0;
                bl_q        <= '0;
                wl_q        <= '0;
                cfg_ready_q <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            state_q     <= ST_LOAD;
                            row_idx_q   <= '0;
                            cfg_ready_q <= 1'b1;
                            busy_q      <= 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        if (buf_full) begin
                            state_q     <= ST_SETUP;
                            cyc_q       <= '0;
                            cfg_ready_q <= 1'b0;
                            bl_q        <= buf_row;
                        end
                    end
                    ST_SETUP: begin
                        if (cyc_q == CYW'(SETUP_CYC - 1)) begin
                            state_q <= ST_PULSE;
                            cyc_q   <= '0;
                            wl_q    <= WL_WIDTH'(1) << row_idx_q;
                        end else begin
                            cyc_q <= cyc_q + 1'b1;
                        end
                    end
                    ST_PULSE: begin
                        if (cyc_q == CYW'(PULSE_CYC - 1)) begin
                            state_q <= ST_HOLD;
                            cyc_q   <= '0;
                            wl_q    <= '0;
                        end else begin
                            cyc_q <= cyc_q + 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        if (cyc_q == CYW'(HOLD_CYC - 1)) begin
                            cyc_q <= '0;
                            bl_q  <= '0;
                            if (row_idx_q == RW'(WL_WIDTH - 1)) begin
                                state_q   <= ST_IDLE;
                                busy_q    <= 1'b0;
                                done_q    <= 1'b1;
                                row_idx_q <= '0;
                            end else begin
                                state_q     <= ST_LOAD;
                                row_idx_q   <= row_idx_q + 1'b1;
                                cfg_ready_q <= 1'b1;
                            end
                        end else begin
                            cyc_q <= cyc_q + 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign bl        = bl_q;
    assign wl        = wl_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign row_idx   = row_idx_q;

endmodule
